seven_seg_scanner: RTL and testbench

- Parametrised multiplexed driver for an N-digit common-anode seven-segment display.
- Successor to the fixed 8-digit controller. Adds:
  - configurable digit count, refresh rate and output polarity;
  - an internal hex decoder;
  - per-digit blank, minus and decimal-point control;
  - tear-free double-buffered loading with a frame-done strobe.
- Sits between the datapath (ALU/calculator result formatting) and the board seg/dp/an pins.

---
 rtl/seven_seg_pkg.sv | 27 ++
 rtl/hex_to_seg_decoder.sv | 15 +
 rtl/seven_seg_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner: active-high segment
// patterns ({g,f,e,d,c,b,a}), segment source selector and index sizing helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF   = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  localparam logic [6:0] HEX_TO_SEG [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    SRC_BLANK = 2'd0,
    SRC_MINUS = 2'd1,
    SRC_HEX   = 2'd2
  } seg_src_e;

  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hex_to_seg_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern ({g..a}).
module hex_to_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the standard 0-F glyphs
  always_comb begin
    seg_o = SEG_OFF;
    seg_o = HEX_TO_SEG[nibble_i];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit seven-segment scanner with double-buffered digit state.
// Optional per-slot anode dimming is built when SEVEN_SEG_DIM_EN is defined.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 262144,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_blank,
  input  logic [NUM_DIGITS-1:0]   digit_minus,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SEVEN_SEG_DIM_EN
  input  logic [3:0]              bright,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW    = 4 * NUM_DIGITS;
  localparam int SW    = 7 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_DARK  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]            SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_DARK  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SW-1:0]         shadow_q, shadow_d;
  logic [SW-1:0]         act_q, act_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  tc_s;
  logic                  boundary_s;
  logic [SW-1:0]         in_s;
  logic [DW-1:0]         act_data_s;
  logic [NUM_DIGITS-1:0] act_blank_s;
  logic [NUM_DIGITS-1:0] act_minus_s;
  logic [NUM_DIGITS-1:0] act_dp_s;
  logic [3:0]            sel_nib_s;
  logic [6:0]            dec_seg_s;
  seg_src_e              src_s;
  logic [6:0]            seg_on_s;
  logic                  dp_on_s;
  logic [NUM_DIGITS-1:0] an_on_s;

`ifdef SEVEN_SEG_DIM_EN
  logic [3:0]       bright_q, bright_d;
  logic [CNT_W+4:0] lim_s;
  logic [CNT_W+4:0] cnt_ext_s;
`endif

  assign in_s        = {dp_in, digit_minus, digit_blank, digit_data};
  assign act_data_s  = act_q[DW-1:0];
  assign act_blank_s = act_q[DW +: NUM_DIGITS];
  assign act_minus_s = act_q[DW+NUM_DIGITS +: NUM_DIGITS];
  assign act_dp_s    = act_q[DW+2*NUM_DIGITS +: NUM_DIGITS];

  // Refresh counter and scan index advance
  always_comb begin
    tc_s       = (cnt_q == CNT_LAST);
    boundary_s = tc_s && (idx_q == IDX_LAST);
    cnt_d      = cnt_q + CNT_W'(1'b1);
    idx_d      = idx_q;
    if (tc_s) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1'b1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Shadow/active double buffer; a load on the boundary bypasses the shadow wait
  always_comb begin
    shadow_d     = shadow_q;
    act_d        = act_q;
    pending_d    = pending_q;
    frame_done_d = boundary_s;
    if (boundary_s) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_d = in_s;
        act_d    = in_s;
      end else if (pending_q) begin
        act_d = shadow_q;
      end else begin
        act_d = act_q;
      end
    end else if (load) begin
      shadow_d  = in_s;
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  assign sel_nib_s = act_data_s[{idx_q, 2'b00} +: 4];

  hex_to_seg_decoder u_dec (
    .nibble_i (sel_nib_s),
    .seg_o    (dec_seg_s)
  );

  // Per-digit segment source priority: blank > minus > hex
  always_comb begin
    src_s = SRC_HEX;
    if (act_blank_s[idx_q]) begin
      src_s = SRC_BLANK;
    end else if (act_minus_s[idx_q]) begin
      src_s = SRC_MINUS;
    end else begin
      src_s = SRC_HEX;
    end
    case (src_s)
      SRC_BLANK: seg_on_s = SEG_OFF;
      SRC_MINUS: seg_on_s = SEG_MINUS;
      SRC_HEX:   seg_on_s = dec_seg_s;
      default:   seg_on_s = SEG_OFF;
    endcase
    dp_on_s = act_dp_s[idx_q] & ~act_blank_s[idx_q];
  end

`ifdef SEVEN_SEG_DIM_EN
  // Brightness is held for a whole slot; the anode lights for the first part of it
  always_comb begin
    bright_d  = tc_s ? bright : bright_q;
    lim_s     = ((CNT_W+5)'({1'b0, bright_q}) + (CNT_W+5)'(1'b1)) * (CNT_W+5)'(REFRESH_DIV);
    lim_s     = lim_s >> 4;
    cnt_ext_s = (CNT_W+5)'(cnt_q);
    if (cnt_ext_s < lim_s) begin
      an_on_s = NUM_DIGITS'(1'b1) << idx_q;
    end else begin
      an_on_s = {NUM_DIGITS{1'b0}};
    end
  end
`else
  // One anode per slot, lit for the whole slot
  always_comb begin
    an_on_s = NUM_DIGITS'(1'b1) << idx_q;
  end
`endif

  // Board polarity is applied just ahead of the output registers
  always_comb begin
    an_d  = AN_ACTIVE_LOW  ? ~an_on_s  : an_on_s;
    seg_d = SEG_ACTIVE_LOW ? ~seg_on_s : seg_on_s;
    dp_d  = SEG_ACTIVE_LOW ? ~dp_on_s  : dp_on_s;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      shadow_q     <= {SW{1'b0}};
      act_q        <= {SW{1'b0}};
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_DARK;
      seg_q        <= SEG_DARK;
      dp_q         <= DP_DARK;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      act_q        <= act_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

`ifdef SEVEN_SEG_DIM_EN
  // Reset samples the live brightness so the first slot is already dimmed
  always_ff @(posedge clk) begin
    if (rst) begin
      bright_q <= bright;
    end else begin
      bright_q <= bright_d;
    end
  end
`endif

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 8 digits, 4-cycle slots, active-low pins.
module tb_seven_seg_scanner;

  localparam int ND = 8;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] digit_data;
  logic [7:0]  digit_blank;
  logic [7:0]  digit_minus;
  logic [7:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_done;
  logic        pending;
`ifdef SEVEN_SEG_DIM_EN
  logic [3:0]  bright;
`endif

  int total = 0;
  int bad   = 0;

  // Active-low glyphs for data 32'h76543210, digits 0..7
  logic [6:0] exp_a [0:7] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  // Second load: data FEDCBA98, digit 2 blank+minus, digit 3 minus+dp
  logic [6:0] exp_b [0:7] = '{7'h00, 7'h10, 7'h7F, 7'h3F, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic       exp_bdp [0:7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .digit_data  (digit_data),
    .digit_blank (digit_blank),
    .digit_minus (digit_minus),
    .dp_in       (dp_in),
`ifdef SEVEN_SEG_DIM_EN
    .bright      (bright),
`endif
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done),
    .pending     (pending)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    rst         = 1'b1;
    load        = 1'b0;
    digit_data  = 32'h0;
    digit_blank = 8'h00;
    digit_minus = 8'h00;
    dp_in       = 8'h00;
`ifdef SEVEN_SEG_DIM_EN
    bright      = 4'hF;
`endif

    tick();
    check_val("rst_an", {24'h0, an}, 32'hFF);
    check_val("rst_seg", {25'h0, seg}, 32'h7F);
    check_val("rst_pend", {31'h0, pending}, 32'h0);
    check_val("rst_fd", {31'h0, frame_done}, 32'h0);
    tick();
    tick();
    check_val("rst_an3", {24'h0, an}, 32'hFF);
    check_val("rst_dp", {31'h0, dp}, 32'h1);

    // Edge 0: release reset with a load (mid-frame, goes to shadow)
    rst        = 1'b0;
    load       = 1'b1;
    digit_data = 32'h76543210;
    tick();
    load = 1'b0;
    check_val("rel_an", {24'h0, an}, 32'hFE);
    check_val("rel_seg", {25'h0, seg}, 32'h40);
    check_val("rel_pend", {31'h0, pending}, 32'h1);

    for (int n = 1; n <= 31; n++) begin
      tick();
      if (n == 16) begin
        check_val("hold_an", {24'h0, an}, 32'hEF);
        check_val("hold_seg", {25'h0, seg}, 32'h40);
        check_val("hold_pend", {31'h0, pending}, 32'h1);
      end
      if (n == 30) begin
        check_val("fd_pre", {31'h0, frame_done}, 32'h0);
      end
    end
    check_val("fd0", {31'h0, frame_done}, 32'h1);
    check_val("pend_clr0", {31'h0, pending}, 32'h0);
    check_val("old_d7_seg", {25'h0, seg}, 32'h40);
    check_val("old_d7_an", {24'h0, an}, 32'h7F);

    // Frame 1: scan 76543210; a mid-frame load at edge 40 must not show yet
    for (int n = 32; n <= 63; n++) begin
      if (n == 40) begin
        load        = 1'b1;
        digit_data  = 32'hFEDCBA98;
        digit_blank = 8'h04;
        digit_minus = 8'h0C;
        dp_in       = 8'h0C;
      end
      tick();
      load = 1'b0;
      d = (n - 32) / 4;
      check_val($sformatf("scan_an_%0d", n), {24'h0, an}, {24'h0, ~(8'h01 << d)});
      check_val($sformatf("scan_seg_%0d", n), {25'h0, seg}, {25'h0, exp_a[d]});
      check_val($sformatf("scan_fd_%0d", n), {31'h0, frame_done}, (n == 63) ? 32'h1 : 32'h0);
      if (n == 40) begin
        check_val("mid_pend", {31'h0, pending}, 32'h1);
      end
    end
    check_val("pend_clr1", {31'h0, pending}, 32'h0);

    // Frame 2: second load applied; load on the boundary edge 95
    for (int n = 64; n <= 95; n++) begin
      if (n == 95) begin
        load        = 1'b1;
        digit_data  = 32'h11111111;
        digit_blank = 8'h00;
        digit_minus = 8'h00;
        dp_in       = 8'h00;
      end
      tick();
      load = 1'b0;
      if ((n % 4) == 0) begin
        d = (n - 64) / 4;
        check_val($sformatf("pri_seg_%0d", d), {25'h0, seg}, {25'h0, exp_b[d]});
        check_val($sformatf("pri_dp_%0d", d), {31'h0, dp}, {31'h0, exp_bdp[d]});
        check_val($sformatf("pri_an_%0d", d), {24'h0, an}, {24'h0, ~(8'h01 << d)});
      end
    end
    check_val("coll_fd", {31'h0, frame_done}, 32'h1);
    check_val("coll_pend", {31'h0, pending}, 32'h0);
    tick();
    check_val("coll_seg", {25'h0, seg}, 32'h79);
    check_val("coll_an", {24'h0, an}, 32'hFE);
    check_val("coll_pend2", {31'h0, pending}, 32'h0);

    // Reset mid-frame with a pending load: all state discarded
    for (int n = 97; n <= 100; n++) begin
      if (n == 100) begin
        load       = 1'b1;
        digit_data = 32'h22222222;
      end
      tick();
      load = 1'b0;
    end
    check_val("mrst_pend_pre", {31'h0, pending}, 32'h1);
    rst = 1'b1;
    tick();
    check_val("mrst_an", {24'h0, an}, 32'hFF);
    check_val("mrst_pend", {31'h0, pending}, 32'h0);
    rst = 1'b0;
    tick();
    check_val("mrst_rel_an", {24'h0, an}, 32'hFE);
    check_val("mrst_rel_seg", {25'h0, seg}, 32'h40);

`ifdef SEVEN_SEG_DIM_EN
    begin
      int lit;
      bright = 4'h3;
      for (int n = 0; n < 8; n++) tick();
      lit = 0;
      for (int n = 0; n < 16; n++) begin
        tick();
        if (an != 8'hFF) lit++;
      end
      check_val("dim_lit", lit, 32'd4);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
